monobit_stream_gen: RTL and testbench
=====================================

# monobit_stream_gen

Bit-stream source for the monobit frequency tester: produces fixed-length blocks of test bits over a valid/ready serial handshake, from a 16-bit Galois LFSR or one of three deterministic patterns. It is the producer end of the tester's serial bit input. On silicon it drives the tester from on-chip stimulus; in simulation it gives known-answer streams.

## Interface
Parameters:
- BLOCK_LEN, 128: bits per block; 2..65535.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low; one clock, sampled on rising clk edge
- ena  in  1  design enable; low freezes all state
- mode  in  2  source select, sampled on start: 00 LFSR, 01 all ones, 10 byte-pattern replay, 11 alternating 0101…
- pattern  in  8  replay byte (mode 10); seed source on seed_load
- seed_load  in  1  IDLE only: LFSR <= {pattern, ~pattern}
- start  in  1  pulse; begins a block from IDLE, ignored otherwise
- stop  in  1  aborts the current block
- bit_out  out  1  data bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  consumer accepts bit this cycle
- bit_last  out  1  high with the final bit of a block
- busy  out  1  high in RUN and DONE
- block_count  out  8  completed blocks, wraps 255->0

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: start -> RUN; latch mode and pattern; clear bit index. seed_load in IDLE takes effect next edge. If start and seed_load coincide, seed load wins and start is ignored.
- RUN: bit_valid=1. A transfer occurs on bit_valid && bit_ready. On transfer, the index increments and the source advances. The transfer at index BLOCK_LEN-1 -> DONE.
- DONE: one cycle, bit_valid=0, block_count+1 -> IDLE.
- stop in RUN/DONE -> IDLE next edge, no count increment. An in-flight transfer in the same cycle still completes at the consumer, but is discarded by the generator. stop beats start.
- Sources, with bit index i:
  - LFSR: bit_out = lfsr[0]. Advance: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Ones: 1.
  - Pattern: pattern_q[i mod 8], LSB first.
  - Alternating: i[0].
- LFSR state persists across blocks; it is reset only by rst_n (to SEED) or seed_load. {pattern,~pattern} is never zero.
- ena=0: no state, register, or output changes. A held bit_valid stays high; the handshake still applies when ena returns.

## Timing
- Reset values: bit_out=0, bit_valid=0, bit_last=0, busy=0, block_count=0, lfsr=SEED, state=IDLE.
- start seen at edge t -> bit_valid=1 from cycle t+1. Throughput is 1 bit/cycle while bit_ready=1.
- bit_out and bit_last are registered and stable while bit_valid && !bit_ready. bit_valid never drops without a transfer, except on stop or rst_n.
- Block duration with bit_ready tied high: BLOCK_LEN RUN cycles + 1 DONE cycle. busy spans the same window.
- block_count updates on the edge leaving DONE.
- rst_n low mid-block -> all reset values next edge. The partial block is lost.

## Structure
- Shared package monobit_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - mode constants MODE_LFSR, MODE_ONES, MODE_PAT, MODE_ALT
  - LFSR_TAPS = 16'hB400
  - default SEED
- Sub-module monobit_lfsr16: state register, seed load, advance enable, bit output. The top holds the FSM, index counter, mux and handshake.

## Test plan
- Reset then LFSR mode, start, bit_ready=1: first bits 1,0,0,0; valid 1 cycle after start; bit_last at bit 128; block_count=1 after DONE.
- Backpressure: toggle bit_ready pseudo-randomly, mode 10, pattern=8'hA5. Required: stream 1,0,1,0,0,1,0,1 repeats; bit_out stable during stalls; exactly 128 transfers.
- seed_load with pattern=8'h3C, then LFSR block. Required: lfsr starts 16'h3CC3, first bit 1. seed_load+start in the same cycle: no block starts.
- stop at transfer 50, mode 01. Required: IDLE next edge, bit_valid=0, block_count unchanged, busy=0.
- 256 back-to-back blocks with BLOCK_LEN=2, mode 11. Required: bits 0,1 per block; block_count wraps to 0.
- ena=0 for 5 cycles mid-block with bit_ready=1. Required: no transfers, outputs frozen; the block resumes and completes with 128 total transfers.

Source files
------------

// File: rtl/monobit_pkg.sv
// Shared types and constants for the monobit stream generator.
// The two helpers are the LFSR step and the per-mode bit select.
package monobit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_LFSR = 2'b00;
  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_PAT  = 2'b10;
  localparam logic [1:0] MODE_ALT  = 2'b11;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Galois right-shift step: the bit shifted out selects the tap mask.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Only the low three index bits matter: pattern bits repeat every 8,
  // and the alternating source is index bit 0.
  function automatic logic src_bit(input logic [1:0] mode,
                                   input logic [7:0] pat,
                                   input logic [2:0] idx,
                                   input logic       lfsr_bit);
    case (mode)
      MODE_ONES: return 1'b1;
      MODE_PAT:  return pat[idx];
      MODE_ALT:  return idx[0];
      default:   return lfsr_bit;
    endcase
  endfunction

endpackage

// File: rtl/monobit_lfsr16.sv
// 16-bit Galois LFSR bit source with a seed load and an advance enable.
// It presents the current output bit and the bit the next step would give.
module monobit_lfsr16
  import monobit_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        advance_i,
  output logic        bit_o,
  output logic        next_bit_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_next;

  assign lfsr_next  = lfsr_step(lfsr_q);
  assign bit_o      = lfsr_q[0];
  assign next_bit_o = lfsr_next[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (ena_i) begin
      if (load_i) begin
        lfsr_q <= seed_i;
      end else if (advance_i) begin
        lfsr_q <= lfsr_next;
      end
    end
  end

endmodule

// File: rtl/monobit_stream_gen.sv
// Block-oriented test-bit source over a valid/ready serial handshake.
// It holds the FSM, the bit index, the source mux and registered outputs.
module monobit_stream_gen
  import monobit_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = 128,
  parameter logic [15:0] SEED      = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] mode,
  input  logic [7:0] pattern,
  input  logic       seed_load,
  input  logic       start,
  input  logic       stop,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       bit_last,
  output logic       busy,
  output logic [7:0] block_count
);

  localparam logic [15:0] LAST_IDX = 16'(BLOCK_LEN - 1);

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] idx_inc;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  pat_q, pat_d;
  logic        bit_q, bit_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic [7:0]  count_q, count_d;

  logic xfer;
  logic lfsr_load;
  logic lfsr_adv;
  logic lfsr_bit;
  logic lfsr_next_bit;

  assign xfer      = (state_q == RUN) && valid_q && bit_ready;
  assign lfsr_load = (state_q == IDLE) && seed_load;
  // A transfer coinciding with stop is dropped, so the LFSR must not move.
  assign lfsr_adv  = xfer && !stop && (mode_q == MODE_LFSR);
  assign idx_inc   = idx_q + 16'd1;

  monobit_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena_i      (ena),
    .load_i     (lfsr_load),
    .seed_i     ({pattern, ~pattern}),
    .advance_i  (lfsr_adv),
    .bit_o      (lfsr_bit),
    .next_bit_o (lfsr_next_bit)
  );

  // NOTE: every next-state signal takes its current value first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start && !seed_load && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          pat_d   = pattern;
          idx_d   = '0;
          bit_d   = src_bit(mode, pattern, 3'd0, lfsr_bit);
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_inc;
            bit_d  = src_bit(mode_q, pat_q, idx_inc[2:0], lfsr_next_bit);
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!stop) begin
          count_d = count_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= MODE_LFSR;
      pat_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else if (ena) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign bit_out     = bit_q;
  assign bit_valid   = valid_q;
  assign bit_last    = last_q;
  assign busy        = busy_q;
  assign block_count = count_q;

endmodule

// File: tb/tb_monobit_stream_gen.sv
// Scoreboard bench for monobit_stream_gen: stimulus pushes expected bits,
// monitors pop and compare on every accepted transfer.
module tb_monobit_stream_gen;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] mode;
  logic [7:0] pattern;
  logic       seed_load;
  logic       start;
  logic       stop;
  logic       bit_ready;
  logic       bit_out, bit_valid, bit_last, busy;
  logic [7:0] block_count;

  logic       start2;
  logic       bit_ready2;
  logic       bit_out2, bit_valid2, bit_last2, busy2;
  logic [7:0] block_count2;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int xfers2 = 0;

  exp_t exp_q[$];
  exp_t exp2_q[$];

  logic [15:0] model;
  logic        a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        lfsr_first [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  monobit_stream_gen dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .pattern(pattern),
    .seed_load(seed_load), .start(start), .stop(stop),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_last(bit_last), .busy(busy), .block_count(block_count)
  );

  monobit_stream_gen #(.BLOCK_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .pattern(pattern),
    .seed_load(seed_load), .start(start2), .stop(stop),
    .bit_out(bit_out2), .bit_valid(bit_valid2), .bit_ready(bit_ready2),
    .bit_last(bit_last2), .busy(busy2), .block_count(block_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 128-bit instance; also checks hold-stability under stalls.
  logic stalled = 1'b0;
  logic held_b, held_l;
  always @(negedge clk) begin
    if (rst_n && ena) begin
      if (bit_valid && bit_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check("exp_q_nonempty", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("bit_out", bit_out, e.b);
          check("bit_last", bit_last, e.last);
        end
      end
      if (stalled && bit_valid) begin
        check("stall_bit_stable", bit_out, held_b);
        check("stall_last_stable", bit_last, held_l);
      end
      stalled = bit_valid && !bit_ready;
      held_b  = bit_out;
      held_l  = bit_last;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ena && bit_valid2 && bit_ready2) begin
      xfers2++;
      if (exp2_q.size() == 0) begin
        check("exp2_q_nonempty", exp2_q.size(), 1);
      end else begin
        exp_t e;
        e = exp2_q.pop_front();
        check("bit_out2", bit_out2, e.b);
        check("bit_last2", bit_last2, e.last);
      end
    end
  end

  task automatic start_block(input logic [1:0] m, input logic [7:0] p);
    mode    = m;
    pattern = p;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("valid_after_start", bit_valid, 1'b1);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_idle(input string name, input int budget, input bit rnd);
    int n = 0;
    while (busy && n < budget) begin
      if (rnd) bit_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check(name, busy, 1'b0);
    bit_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_cnt;
    logic       snap_b, snap_v, snap_l, snap_busy;
    int         n;

    rst_n = 1'b0; ena = 1'b1; mode = 2'b00; pattern = 8'h00;
    seed_load = 1'b0; start = 1'b0; stop = 1'b0;
    bit_ready = 1'b1; start2 = 1'b0; bit_ready2 = 1'b1;
    repeat (3) tick();
    check("rst_bit_out", bit_out, 1'b0);
    check("rst_bit_valid", bit_valid, 1'b0);
    check("rst_bit_last", bit_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_block_count", block_count, 8'd0);
    check("rst_block_count2", block_count2, 8'd0);
    rst_n = 1'b1;
    tick();

    // LFSR block from the reset seed; first four bits are hand values.
    model = 16'hACE1;
    for (int i = 0; i < 128; i++) begin
      if (i < 4) exp_q.push_back('{b: lfsr_first[i], last: 1'b0});
      else       exp_q.push_back('{b: model[0], last: (i == 127)});
      model = lfsr_adv(model);
    end
    xfers = 0;
    start_block(2'b00, 8'h00);
    check("lfsr_first_bit", bit_out, 1'b1);
    wait_idle("lfsr_block_done", 300, 1'b0);
    check("lfsr_xfers", xfers, 128);
    check("lfsr_count", block_count, 8'd1);

    // Pattern replay of 8'hA5 under random backpressure.
    for (int i = 0; i < 128; i++)
      exp_q.push_back('{b: a5_bits[i % 8], last: (i == 127)});
    xfers = 0;
    start_block(2'b10, 8'hA5);
    wait_idle("pat_block_done", 2000, 1'b1);
    check("pat_xfers", xfers, 128);
    check("pat_count", block_count, 8'd2);
    check("pat_q_drained", exp_q.size(), 0);

    // seed_load with start in the same cycle: seed taken, no block.
    mode = 2'b00; pattern = 8'h3C; seed_load = 1'b1; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    check("seed_start_no_valid", bit_valid, 1'b0);
    check("seed_start_no_busy", busy, 1'b0);
    check("seed_lfsr_state", dut.u_lfsr.lfsr_q, 16'h3CC3);
    model = 16'h3CC3;
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back('{b: model[0], last: (i == 127)});
      model = lfsr_adv(model);
    end
    xfers = 0;
    start_block(2'b00, 8'h3C);
    check("seed_first_bit", bit_out, 1'b1);
    wait_idle("seed_block_done", 300, 1'b0);
    check("seed_xfers", xfers, 128);
    check("seed_count", block_count, 8'd3);

    // Abort after the 50th transfer in all-ones mode.
    for (int i = 0; i < 50; i++) exp_q.push_back('{b: 1'b1, last: 1'b0});
    xfers = 0;
    start_block(2'b01, 8'h00);
    n = 0;
    while (xfers < 49 && n < 200) begin tick(); n++; end
    check("stop_reached_49", xfers, 49);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_valid", bit_valid, 1'b0);
    check("stop_busy", busy, 1'b0);
    check("stop_last", bit_last, 1'b0);
    check("stop_count", block_count, 8'd3);
    check("stop_xfers", xfers, 50);
    repeat (3) tick();
    check("stop_stays_idle", busy, 1'b0);
    check("stop_q_drained", exp_q.size(), 0);

    // ena low for five cycles in the middle of an alternating block.
    for (int i = 0; i < 128; i++) begin
      logic [31:0] iv;
      iv = i;
      exp_q.push_back('{b: iv[0], last: (i == 127)});
    end
    xfers = 0;
    start_block(2'b11, 8'h00);
    n = 0;
    while (xfers < 20 && n < 200) begin tick(); n++; end
    snap_b = bit_out; snap_v = bit_valid; snap_l = bit_last; snap_busy = busy;
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("ena_bit_frozen", bit_out, snap_b);
      check("ena_valid_frozen", bit_valid, snap_v);
      check("ena_last_frozen", bit_last, snap_l);
      check("ena_busy_frozen", busy, snap_busy);
      check("ena_no_xfers", xfers, 20);
    end
    ena = 1'b1;
    wait_idle("ena_block_done", 300, 1'b0);
    check("ena_xfers", xfers, 128);
    check("ena_count", block_count, 8'd4);

    // 256 back-to-back 2-bit alternating blocks on the short instance.
    mode = 2'b11;
    xfers2 = 0;
    exp_cnt = 8'd0;
    for (int k = 0; k < 256; k++) begin
      exp2_q.push_back('{b: 1'b0, last: 1'b0});
      exp2_q.push_back('{b: 1'b1, last: 1'b1});
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      n = 0;
      while (busy2 && n < 10) begin tick(); n++; end
      exp_cnt = exp_cnt + 8'd1;
      check("short_block_count", block_count2, exp_cnt);
    end
    check("short_wrap_zero", block_count2, 8'd0);
    check("short_xfers", xfers2, 512);
    check("short_q_drained", exp2_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
